// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, ASCII ranges, unit counts, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package morse_pkg;

  // Symbol strobe codes, shared with the push-button decoder
  localparam logic [1:0] SYM_NONE  = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_DASH  = 2'b10;
  localparam logic [1:0] SYM_SPACE = 2'b11;

  // ASCII ranges the encoder understands
  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_DIGIT_LO    = 8'h30;
  localparam logic [7:0] ASCII_DIGIT_HI    = 8'h39;
  localparam logic [7:0] ASCII_UPPER_LO    = 8'h41;
  localparam logic [7:0] ASCII_UPPER_HI    = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_LO    = 8'h61;
  localparam logic [7:0] ASCII_LOWER_HI    = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  // Durations in Morse time units
  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] GAP_UNITS        = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
  localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  // Lookup result. pat is left-aligned: pat[4] is the first element,
  // pat[4-len+1] the last; 1 = dash. A space is supported with len = 0.
  typedef struct packed {
    logic       supported;
    logic [2:0] len;
    logic [4:0] pat;
  } rom_entry_t;

endpackage

// File: rtl/morse_char_rom.sv
// ASCII -> Morse pattern lookup (letters folded to uppercase, digits, space).
// Latency: combinational.
// Backpressure: none.
module morse_char_rom
  import morse_pkg::*;
(
  input  logic [7:0]  char_in,
  output rom_entry_t  entry
);

  logic [7:0] upper;

  function automatic rom_entry_t ent(input logic [2:0] l, input logic [4:0] p);
    return {1'b1, l, p};
  endfunction

  // Fold lowercase letters onto their uppercase codes
  always_comb begin
    upper = char_in;
    if (char_in >= ASCII_LOWER_LO && char_in <= ASCII_LOWER_HI)
      upper = char_in - ASCII_CASE_OFFSET;
  end

  // International Morse table; anything not listed is unsupported
  always_comb begin
    entry = '0;
    case (upper)
      ASCII_SPACE: entry = ent(3'd0, 5'b00000);
      8'h41: entry = ent(3'd2, 5'b01000); // A .-
      8'h42: entry = ent(3'd4, 5'b10000); // B -...
      8'h43: entry = ent(3'd4, 5'b10100); // C -.-.
      8'h44: entry = ent(3'd3, 5'b10000); // D -..
      8'h45: entry = ent(3'd1, 5'b00000); // E .
      8'h46: entry = ent(3'd4, 5'b00100); // F ..-.
      8'h47: entry = ent(3'd3, 5'b11000); // G --.
      8'h48: entry = ent(3'd4, 5'b00000); // H ....
      8'h49: entry = ent(3'd2, 5'b00000); // I ..
      8'h4A: entry = ent(3'd4, 5'b01110); // J .---
      8'h4B: entry = ent(3'd3, 5'b10100); // K -.-
      8'h4C: entry = ent(3'd4, 5'b01000); // L .-..
      8'h4D: entry = ent(3'd2, 5'b11000); // M --
      8'h4E: entry = ent(3'd2, 5'b10000); // N -.
      8'h4F: entry = ent(3'd3, 5'b11100); // O ---
      8'h50: entry = ent(3'd4, 5'b01100); // P .--.
      8'h51: entry = ent(3'd4, 5'b11010); // Q --.-
      8'h52: entry = ent(3'd3, 5'b01000); // R .-.
      8'h53: entry = ent(3'd3, 5'b00000); // S ...
      8'h54: entry = ent(3'd1, 5'b10000); // T -
      8'h55: entry = ent(3'd3, 5'b00100); // U ..-
      8'h56: entry = ent(3'd4, 5'b00010); // V ...-
      8'h57: entry = ent(3'd3, 5'b01100); // W .--
      8'h58: entry = ent(3'd4, 5'b10010); // X -..-
      8'h59: entry = ent(3'd4, 5'b10110); // Y -.--
      8'h5A: entry = ent(3'd4, 5'b11000); // Z --..
      8'h30: entry = ent(3'd5, 5'b11111); // 0
      8'h31: entry = ent(3'd5, 5'b01111); // 1
      8'h32: entry = ent(3'd5, 5'b00111); // 2
      8'h33: entry = ent(3'd5, 5'b00011); // 3
      8'h34: entry = ent(3'd5, 5'b00001); // 4
      8'h35: entry = ent(3'd5, 5'b00000); // 5
      8'h36: entry = ent(3'd5, 5'b10000); // 6
      8'h37: entry = ent(3'd5, 5'b11000); // 7
      8'h38: entry = ent(3'd5, 5'b11100); // 8
      8'h39: entry = ent(3'd5, 5'b11110); // 9
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// ASCII character in (valid/ready) -> timed Morse key output plus symbol strobes.
// Latency: key_out/sym_out/err register the transfer edge, so they move in cycle 1.
// Backpressure: char_ready only in IDLE; a character is held off until the previous one (incl. gaps) is done.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic [1:0] sym_out,
  output logic       busy,
  output logic       err
);

  localparam int             CW       = $clog2(UNIT_CYCLES + 1);
  localparam logic [CW-1:0]  CYC_LAST = CW'(UNIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cyc_q;
  logic [2:0]  unit_q;
  logic [2:0]  elem_q;
  logic [2:0]  len_q;
  logic [4:0]  pat_q;
  rom_entry_t  rom;

  logic        xfer;
  logic        unit_tick;
  logic [2:0]  need_units;
  logic        state_done;
  logic        last_elem;
  logic        next_dash;
  logic        key_d;
  logic [1:0]  sym_d;
  logic        err_d;

  morse_char_rom u_rom (
    .char_in (char_in),
    .entry   (rom)
  );

  assign char_ready = (state_q == IDLE);
  assign busy       = ~char_ready;
  assign xfer       = char_valid && char_ready;
  assign unit_tick  = (cyc_q == CYC_LAST);
  assign state_done = unit_tick && (unit_q == need_units - 3'd1);
  assign last_elem  = (elem_q == len_q - 3'd1);

  // Units the current state lasts; the current element is always pat_q[4]
  always_comb begin
    need_units = GAP_UNITS;
    case (state_q)
      MARK:     need_units = pat_q[4] ? DASH_UNITS : DOT_UNITS;
      GAP:      need_units = GAP_UNITS;
      CHAR_GAP: need_units = CHAR_GAP_UNITS;
      WORD_GAP: need_units = WORD_EXTRA_UNITS;
      default:  need_units = GAP_UNITS;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (xfer && rom.supported) state_d = (rom.len == 3'd0) ? WORD_GAP : MARK;
      MARK:     if (state_done) state_d = last_elem ? CHAR_GAP : GAP;
      GAP:      if (state_done) state_d = MARK;
      CHAR_GAP: if (state_done) state_d = IDLE;
      WORD_GAP: if (state_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode: computed from the upcoming state so the registered outputs line up with it
  always_comb begin
    next_dash = (state_q == IDLE) ? rom.pat[4] : pat_q[3];
    key_d     = (state_d == MARK);
    sym_d     = SYM_NONE;
    if (state_d != state_q) begin
      case (state_d)
        MARK:     sym_d = next_dash ? SYM_DASH : SYM_DOT;
        CHAR_GAP: sym_d = SYM_SPACE;
        WORD_GAP: sym_d = SYM_SPACE;
        default:  sym_d = SYM_NONE;
      endcase
    end
    err_d = xfer && !rom.supported;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out <= 1'b0;
      sym_out <= SYM_NONE;
      err     <= 1'b0;
    end else begin
      key_out <= key_d;
      sym_out <= sym_d;
      err     <= err_d;
    end
  end

  // Cycle/unit counters restart on every state entry and are parked in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      unit_q <= '0;
    end else if (state_d != state_q || state_q == IDLE) begin
      cyc_q  <= '0;
      unit_q <= '0;
    end else if (unit_tick) begin
      cyc_q  <= '0;
      unit_q <= unit_q + 3'd1;
    end else begin
      cyc_q  <= cyc_q + CW'(1);
    end
  end

  // Latch the pattern at transfer and step to the next element on each GAP -> MARK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      pat_q  <= '0;
      elem_q <= '0;
    end else if (xfer) begin
      len_q  <= rom.len;
      pat_q  <= rom.pat;
      elem_q <= '0;
    end else if (state_q == GAP && state_d == MARK) begin
      pat_q  <= {pat_q[3:0], 1'b0};
      elem_q <= elem_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder with UNIT_CYCLES = 4.
// A dot/dash string table expands each accepted character into its per-cycle waveform.
// Directed cases pin that model; randomized traffic is compared every cycle.
module tb_morse_encoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, key_out, busy, err;
  logic [1:0] sym_out;

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .sym_out    (sym_out),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       key;
    logic [1:0] sym;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t  wave_q[$];
  exp_t  exp_q[$];
  int    xfer_log[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    cur_rdy = 1'b1;

  string tbl[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, req);
    end
  endtask

  // -1 unsupported, -2 space, else index into tbl
  function automatic int tbl_idx(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
    if (u >= 8'h41 && u <= 8'h5A) return int'(u - 8'h41);
    if (u >= 8'h30 && u <= 8'h39) return 26 + int'(u - 8'h30);
    if (u == 8'h20) return -2;
    return -1;
  endfunction

  task automatic push_n(input int n, input logic key, input logic [1:0] first_sym);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.key = key;
      e.sym = (i == 0) ? first_sym : 2'b00;
      e.err = 1'b0;
      e.rdy = 1'b0;
      wave_q.push_back(e);
    end
  endtask

  // Expected waveform for cycles 1..N after accepting character c
  task automatic expand(input logic [7:0] c);
    int    idx;
    string s;
    exp_t  e;
    wave_q.delete();
    idx = tbl_idx(c);
    if (idx == -1) begin
      e.key = 1'b0; e.sym = 2'b00; e.err = 1'b1; e.rdy = 1'b1;
      wave_q.push_back(e);
    end else if (idx == -2) begin
      push_n(4 * U, 1'b0, 2'b11);
    end else begin
      s = tbl[idx];
      for (int i = 0; i < s.len(); i++) begin
        if (s[i] == 8'h2D) push_n(3 * U, 1'b1, 2'b10);
        else               push_n(U, 1'b1, 2'b01);
        if (i != s.len() - 1) push_n(U, 1'b0, 2'b00);
      end
      push_n(3 * U, 1'b0, 2'b11);
    end
  endtask

  function automatic logic [127:0] keys_of();
    logic [127:0] v;
    v = '0;
    foreach (wave_q[i]) v = {v[126:0], wave_q[i].key};
    return v;
  endfunction

  function automatic int count_sym(input logic [1:0] s);
    int n;
    n = 0;
    foreach (wave_q[i]) if (wave_q[i].sym == s) n++;
    return n;
  endfunction

  // Reference model: accept on valid while the model says ready
  always @(posedge clk) begin
    if (rst_n && char_valid && cur_rdy) begin
      xfer_log.push_back(cyc);
      expand(char_in);
      foreach (wave_q[i]) exp_q.push_back(wave_q[i]);
    end
    cyc <= cyc + 1;
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      cur_rdy <= 1'b1;
      chk("reset_outputs", {key_out, sym_out, err, char_ready, busy}, 6'b000010);
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e.key = 1'b0; e.sym = 2'b00; e.err = 1'b0; e.rdy = 1'b1;
      end
      cur_rdy <= e.rdy;
      chk("cycle", {key_out, sym_out, err, char_ready, busy}, {e.key, e.sym, e.err, e.rdy, ~e.rdy});
    end
  end

  task automatic send(input logic [7:0] c);
    bit done;
    done = 1'b0;
    char_in    = c;
    char_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (char_ready) done = 1'b1;
    end
    chk("send_handshake", done, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    char_valid = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && char_ready) done = 1'b1;
    end
    chk("wait_idle", done, 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int         k;

    // Pin the model against hand-derived waveforms
    expand(8'h45);
    chk("model_E_len", wave_q.size(), 16);
    chk("model_E_key", keys_of(), 16'hF000);
    chk("model_E_sym", {wave_q[0].sym, wave_q[4].sym}, 4'b0111);
    expand(8'h41);
    chk("model_A_len", wave_q.size(), 32);
    chk("model_A_key", keys_of(), 32'hF0FFF000);
    chk("model_A_sym", {wave_q[0].sym, wave_q[8].sym, wave_q[20].sym}, 6'b011011);
    expand(8'h61);
    chk("model_a_key", keys_of(), 32'hF0FFF000);
    expand(8'h30);
    chk("model_0_len", wave_q.size(), 88);
    chk("model_0_dashes", count_sym(2'b10), 5);
    chk("model_0_lastmark", {wave_q[75].key, wave_q[76].key}, 2'b10);
    expand(8'h20);
    chk("model_sp_len", wave_q.size(), 16);
    chk("model_sp_key", keys_of(), 0);
    chk("model_sp_sym", wave_q[0].sym, 2'b11);
    expand(8'h23);
    chk("model_hash", {wave_q.size() == 1, wave_q[0]}, 6'b100011);

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 'E', ' ', 'T' with valid held: transfers 17 cycles apart
    xfer_log.delete();
    send(8'h45);
    send(8'h20);
    send(8'h54);
    wait_idle();
    chk("b2b_xfers", xfer_log.size(), 3);
    chk("b2b_gap1", xfer_log[1] - xfer_log[0], 17);
    chk("b2b_gap2", xfer_log[2] - xfer_log[1], 17);

    // 'A' then 'a': ready returns at cycle 33
    xfer_log.delete();
    send(8'h41);
    send(8'h61);
    wait_idle();
    chk("A_ready", xfer_log[1] - xfer_log[0], 33);

    // '0' then 'E': ready returns at cycle 89
    xfer_log.delete();
    send(8'h30);
    send(8'h45);
    wait_idle();
    chk("zero_ready", xfer_log[1] - xfer_log[0], 89);

    // Unsupported chars never drop ready: consecutive transfers
    xfer_log.delete();
    send(8'h23);
    send(8'h23);
    wait_idle();
    chk("hash_b2b", xfer_log[1] - xfer_log[0], 1);

    // Reset in cycle 10 of a 'T' dash
    send(8'h54);
    char_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    chk("pre_reset_key", key_out, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_key", key_out, 0);
    chk("async_reset_ready", {char_ready, busy}, 2'b10);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send(8'h45);
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2: c = 8'h41 + 8'($urandom_range(0, 25));
        3, 4:    c = 8'h61 + 8'($urandom_range(0, 25));
        5, 6:    c = 8'h30 + 8'($urandom_range(0, 9));
        7:       c = 8'h20;
        default: c = 8'($urandom_range(0, 255));
      endcase
      send(c);
      if ($urandom_range(0, 1) == 1) begin
        char_valid = 1'b0;
        char_in    = 8'($urandom_range(0, 255));
        repeat (int'($urandom_range(1, 5))) @(posedge clk);
        #2;
      end
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Converts ASCII characters, delivered over a valid/ready handshake, into a keyed Morse output (key_out) for an LED, buzzer or test line.
- Mirrors the push-button receiver path: the decoder turns dot/dash/char-space symbols into ASCII, and this block turns ASCII back into timed symbols.
- Also emits the same 2-bit symbol strobes the decoder consumes, so a loopback of encoder into decoder is possible.

Parameters:
- UNIT_CYCLES, 25000000, clock cycles per Morse time unit (250 ms at 100 MHz); must be >= 1; benches override to 4.

Ports:
- clk  input  1  system clock (100 MHz on board).
- rst_n  input  1  asynchronous, active-low reset.
- char_in  input  8  ASCII character to send.
- char_valid  input  1  char_in is valid.
- char_ready  output  1  block can accept a character this cycle.
- key_out  output  1  Morse key: 1 = tone/mark, 0 = silence.
- sym_out  output  2  one-cycle symbol strobe: 00 none, 01 dot, 10 dash, 11 char/word space.
- busy  output  1  character in progress; equals ~char_ready.
- err  output  1  one-cycle pulse: accepted character is unsupported.

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted: key_out=0, sym_out=00, err=0, busy=0, char_ready=1, state=IDLE, counters cleared.
- Reset mid-character aborts it. key_out drops immediately and the character is not resumed.
- All outputs are registered, except char_ready and busy, which decode the state.
- Handshake:
  - Transfer occurs on the edge where char_valid && char_ready. The cycle after that edge is cycle 1.
  - char_ready=1 only in IDLE.
  - char_in is latched at transfer and may change afterwards.
- Supported characters:
  - 0x41-0x5A (A-Z).
  - 0x61-0x7A, folded to uppercase.
  - 0x30-0x39 (0-9).
  - 0x20 (space).
  - Standard International Morse patterns. Digits are 5 elements.
- Unsupported character: accepted; err=1 in cycle 1 only; no keying; block stays IDLE, so char_ready remains 1.
- Lookup result is a length (3 bits, 1..5) plus a pattern (5 bits, MSB-first element order, 1=dash).
- Timing, where U = UNIT_CYCLES:
  - Dot mark: 1U.
  - Dash mark: 3U.
  - Intra-character gap: 1U.
  - Every letter/digit ends with a 3U char gap.
  - Space is a 4U silence, so the word gap totals 7U.
- FSM states: IDLE, MARK, GAP, CHAR_GAP, WORD_GAP.
  - IDLE -> MARK: on transfer of a letter/digit. key_out=1 from cycle 1.
  - IDLE -> WORD_GAP: on transfer of a space.
  - MARK -> GAP: at mark end, if elements remain.
  - MARK -> CHAR_GAP: at mark end, if this was the last element.
  - GAP -> MARK: after 1U, with the next element.
  - CHAR_GAP -> IDLE: after 3U.
  - WORD_GAP -> IDLE: after 4U.
- char_ready returns to 1 in the cycle after the last cycle of CHAR_GAP or WORD_GAP.
- Back-to-back: if char_valid is held high, the next character transfers on that first ready cycle.
- sym_out strobes, each asserted for exactly one cycle:
  - 01 or 10 in the first cycle of each MARK.
  - 11 in the first cycle of CHAR_GAP and of WORD_GAP.
  - 00 otherwise.
- Counters:
  - Cycle counter runs 0..U-1 with terminal-count tick; width $clog2(UNIT_CYCLES+1).
  - 3-bit unit counter counts up to 4.
  - 3-bit element index.
  - No wrap beyond these terminal counts.

Decomposition:
- Shared package morse_pkg holds:
  - Symbol codes SYM_NONE=00, SYM_DOT=01, SYM_DASH=10, SYM_SPACE=11, shared with the decoder.
  - ASCII range constants.
  - Unit-count constants DOT_UNITS=1, DASH_UNITS=3, CHAR_GAP_UNITS=3, WORD_EXTRA_UNITS=4.
  - FSM state enum.
- One sub-module, morse_char_rom:
  - Combinational, ASCII in -> {supported, length[2:0], pattern[4:0]}.
  - Handles lowercase folding.
  - Reusable for a future table-driven decoder.

Test Plan (UNIT_CYCLES=4):
- 'E' 0x45 -> key_out=1 cycles 1-4, 0 cycles 5-16; sym_out=01 at cycle 1, 11 at cycle 5; char_ready=1 at cycle 17.
- 'A' 0x41 -> key 1:1-4, 0:5-8, 1:9-20, 0:21-32; sym_out 01@1, 10@9, 11@21; ready at 33. Repeat with 'a' 0x61 for an identical waveform.
- '0' 0x30 -> five 12-cycle marks separated by 4-cycle gaps, last mark ends at cycle 76; sym_out=10 five times; ready at 89.
- Space 0x20 -> key_out=0 throughout, sym_out=11 at cycle 1, ready at 17. Sequence 'E',' ','T' with valid held -> transfers at cycles 0, 17, 34.
- '#' 0x23 -> err=1 at cycle 1 only, key_out stays 0, sym_out=00, char_ready never deasserts.
- Assert rst_n=0 at cycle 10 of a 'T' dash -> key_out=0 asynchronously; after release, char_ready=1 and the next 'E' encodes normally.
